// File: rtl/bcd_ctrl_pkg.sv
// Shared types and helpers for the BCD conversion arbiter.
// Round-robin pick and one double-dabble digit step.
package bcd_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        DONE
    } state_t;

    localparam int MAX_REQ = 32;
    localparam int PTR_W   = 5;

    // First set bit of valid at or above ptr, wrapping at n.
    function automatic logic [PTR_W-1:0] rr_pick(
        input logic [MAX_REQ-1:0] valid,
        input logic [PTR_W-1:0]   ptr,
        input int                 n
    );
        logic found;
        int   idx;
        found   = 1'b0;
        rr_pick = ptr;
        for (int i = 0; i < MAX_REQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= n) idx = idx - n;
            if (!found && i < n) begin
                if (valid[idx[PTR_W-1:0]]) begin
                    found   = 1'b1;
                    rr_pick = idx[PTR_W-1:0];
                end
            end
        end
    endfunction

    // Add-3 correction then shift in_bit in; msb of result is the carry out.
    function automatic logic [4:0] dabble_step(
        input logic [3:0] acc,
        input logic       in_bit
    );
        logic [3:0] adj;
        adj = (acc >= 4'd5) ? acc + 4'd3 : acc;
        return {adj, in_bit};
    endfunction

endpackage

// File: rtl/bcd_convert_arbiter_if.sv
// Request/result bus between clients and the shared BCD converter.
// master = client side, slave = converter side.
interface bcd_convert_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int BIN_W      = 5,
    parameter int BCD_DIGITS = 2
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*BIN_W-1:0] req_data;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     out_valid;
    logic                     out_ready;
    logic [4*BCD_DIGITS-1:0]  out_bcd;
    logic [ID_W-1:0]          out_id;
    logic                     out_ovf;

    modport master (
        output req_valid, req_data, out_ready,
        input  req_ready, out_valid, out_bcd, out_id, out_ovf
    );

    modport slave (
        input  req_valid, req_data, out_ready,
        output req_ready, out_valid, out_bcd, out_id, out_ovf
    );
endinterface

// File: rtl/bcd_dabble_engine.sv
// Bit-serial double-dabble converter, one operand bit per clock.
// done is high during the final shift cycle.
module bcd_dabble_engine
    import bcd_ctrl_pkg::*;
#(
    parameter int BIN_W      = 5,
    parameter int BCD_DIGITS = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [BIN_W-1:0]        din,
    output logic [4*BCD_DIGITS-1:0] bcd,
    output logic                    ovf,
    output logic                    done
);
    localparam int ACC_W = 4 * BCD_DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    logic [BIN_W-1:0] bin_sr;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_nxt;
    logic             carry_out;
    logic [CNT_W-1:0] cnt;

    // Ripple the correct-and-shift through every digit.
    always_comb begin
        logic       c;
        logic [4:0] r;
        acc_nxt   = '0;
        c         = bin_sr[BIN_W-1];
        r         = '0;
        for (int d = 0; d < BCD_DIGITS; d++) begin
            r               = dabble_step(acc[4*d +: 4], c);
            acc_nxt[4*d +: 4] = r[3:0];
            c               = r[4];
        end
        carry_out = c;
    end

    // Load on start, then shift until the counter runs out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_sr <= '0;
            acc    <= '0;
            ovf    <= 1'b0;
            cnt    <= '0;
        end else if (start) begin
            bin_sr <= din;
            acc    <= '0;
            ovf    <= 1'b0;
            cnt    <= CNT_W'(BIN_W);
        end else if (cnt != '0) begin
            bin_sr <= bin_sr << 1;
            acc    <= acc_nxt;
            ovf    <= ovf | carry_out;
            cnt    <= cnt - 1'b1;
        end
    end

    assign done = (cnt == CNT_W'(1));
    assign bcd  = acc;

endmodule

// File: rtl/bcd_convert_arbiter.sv
// Round-robin front end sharing one double-dabble engine.
// One request in flight; next grant only after the result is taken.
module bcd_convert_arbiter
    import bcd_ctrl_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int BIN_W      = 5,
    parameter int BCD_DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    bcd_convert_arbiter_if.slave  bus,
    output logic                  busy
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t              state;
    state_t              state_nxt;
    logic [ID_W-1:0]     rr_ptr;
    logic [ID_W-1:0]     id_reg;
    logic [ID_W-1:0]     gnt;
    logic                start;
    logic                eng_done;
    logic [NUM_REQ-1:0]  ready;
    logic                valid;
    logic [BIN_W-1:0]    din;

    // Pick the winner among pending requests starting at rr_ptr.
    always_comb begin
        gnt = ID_W'(rr_pick(MAX_REQ'(bus.req_valid), PTR_W'(rr_ptr), NUM_REQ));
        din = bus.req_data[gnt*BIN_W +: BIN_W];
    end

    // Next state, grant strobe and result valid.
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        ready     = '0;
        valid     = 1'b0;
        unique case (state)
            IDLE: begin
                if (|bus.req_valid) begin
                    start     = 1'b1;
                    ready     = NUM_REQ'(1) << gnt;
                    state_nxt = CONVERT;
                end
            end
            CONVERT: begin
                if (eng_done) state_nxt = DONE;
            end
            DONE: begin
                valid = 1'b1;
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, owner tag and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            rr_ptr <= '0;
            id_reg <= '0;
        end else begin
            state <= state_nxt;
            if (start) id_reg <= gnt;
            if (state == DONE && bus.out_ready) begin
                if (id_reg == ID_W'(NUM_REQ - 1)) rr_ptr <= '0;
                else                              rr_ptr <= id_reg + 1'b1;
            end
        end
    end

    bcd_dabble_engine #(
        .BIN_W      (BIN_W),
        .BCD_DIGITS (BCD_DIGITS)
    ) u_engine (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .din   (din),
        .bcd   (bus.out_bcd),
        .ovf   (bus.out_ovf),
        .done  (eng_done)
    );

    assign bus.req_ready = ready;
    assign bus.out_valid = valid;
    assign bus.out_id    = id_reg;
    assign busy          = (state != IDLE);

endmodule

// File: tb/tb_bcd_convert_arbiter.sv
// Directed bench for the shared BCD converter.
// Main instance has 2 digits, a second one has 1 digit.
module tb_bcd_convert_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy0;
    logic busy1;
    int   tests = 0;
    int   fails = 0;

    bcd_convert_arbiter_if #(.NUM_REQ(4), .BIN_W(5), .BCD_DIGITS(2)) bus ();
    bcd_convert_arbiter_if #(.NUM_REQ(4), .BIN_W(5), .BCD_DIGITS(1)) bus1 ();

    bcd_convert_arbiter #(.NUM_REQ(4), .BIN_W(5), .BCD_DIGITS(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy0)
    );

    bcd_convert_arbiter #(.NUM_REQ(4), .BIN_W(5), .BCD_DIGITS(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1),
        .busy  (busy1)
    );

    always #5 clk = ~clk;

    task automatic do_reset;
        rst_n          = 1'b0;
        bus.req_valid  = '0;
        bus.out_ready  = 1'b0;
        bus1.req_valid = '0;
        bus1.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // One request from requester r, waits for the result and consumes it.
    task automatic convert(
        input  bit          sel,
        input  int          r,
        input  logic [4:0]  v,
        output logic [3:0]  rdy,
        output logic [7:0]  bcd,
        output logic [1:0]  id,
        output logic        ovf,
        output int          lat
    );
        logic ov;
        @(negedge clk);
        if (!sel) begin
            bus.req_data[r*5 +: 5] = v;
            bus.req_valid[r]       = 1'b1;
        end else begin
            bus1.req_data[r*5 +: 5] = v;
            bus1.req_valid[r]       = 1'b1;
        end
        #1;
        rdy = sel ? bus1.req_ready : bus.req_ready;
        @(negedge clk);
        bus.req_valid  = '0;
        bus1.req_valid = '0;
        lat = 1;
        ov  = sel ? bus1.out_valid : bus.out_valid;
        while (!ov && lat < 30) begin
            @(negedge clk);
            lat++;
            ov = sel ? bus1.out_valid : bus.out_valid;
        end
        if (!ov) lat = -1;
        bcd = sel ? {4'h0, bus1.out_bcd} : bus.out_bcd;
        id  = sel ? bus1.out_id : bus.out_id;
        ovf = sel ? bus1.out_ovf : bus.out_ovf;
        if (!sel) bus.out_ready = 1'b1;
        else      bus1.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready  = 1'b0;
        bus1.out_ready = 1'b0;
    endtask

    task automatic test_reset;
        bus.req_data  = '0;
        bus1.req_data = '0;
        do_reset;
        tests++;
        if ({bus.out_valid, bus.out_bcd, bus.out_id, bus.out_ovf, busy0, bus.req_ready} !== 17'h0) begin
            fails++;
            $display("FAIL reset_outputs: got v=%b bcd=%h id=%0d ovf=%b busy=%b rdy=%b want all zero",
                     bus.out_valid, bus.out_bcd, bus.out_id, bus.out_ovf, busy0, bus.req_ready);
        end
    endtask

    task automatic test_single;
        logic [3:0] rdy;
        logic [7:0] bcd;
        logic [1:0] id;
        logic       ovf;
        int         lat;
        convert(0, 0, 5'd31, rdy, bcd, id, ovf, lat);
        tests++;
        if (rdy !== 4'b0001) begin
            fails++; $display("FAIL single_ready: got %b want 0001", rdy);
        end
        tests++;
        if (lat !== 6) begin
            fails++; $display("FAIL single_latency: got %0d want 6", lat);
        end
        tests++;
        if ({bcd, id, ovf} !== {8'h31, 2'd0, 1'b0}) begin
            fails++; $display("FAIL single_result: got bcd=%h id=%0d ovf=%b want 31 0 0", bcd, id, ovf);
        end
        #1;
        tests++;
        if ({bus.out_valid, busy0} !== 2'b00) begin
            fails++; $display("FAIL single_drop: got v=%b busy=%b want 0 0", bus.out_valid, busy0);
        end
    endtask

    task automatic test_round_robin;
        int         pulses[4];
        int         res_n;
        int         last_c;
        logic [3:0] acc_mask;
        logic [7:0] exp_bcd[4];
        exp_bcd = '{8'h03, 8'h10, 8'h19, 8'h27};
        pulses  = '{0, 0, 0, 0};
        do_reset;
        bus.req_data  = {5'd27, 5'd19, 5'd10, 5'd3};
        bus.req_valid = 4'hf;
        bus.out_ready = 1'b1;
        acc_mask = '0;
        res_n    = 0;
        last_c   = 0;
        for (int c = 0; c < 60 && res_n < 4; c++) begin
            if (c > 0) @(negedge clk);
            bus.req_valid = bus.req_valid & ~acc_mask;
            #1;
            for (int i = 0; i < 4; i++) if (bus.req_ready[i]) pulses[i]++;
            acc_mask = bus.req_ready;
            if (bus.out_valid) begin
                tests++;
                if ({bus.out_id, bus.out_bcd} !== {2'(res_n), exp_bcd[res_n]}) begin
                    fails++;
                    $display("FAIL rr_result%0d: got id=%0d bcd=%h want id=%0d bcd=%h",
                             res_n, bus.out_id, bus.out_bcd, res_n, exp_bcd[res_n]);
                end
                if (res_n > 0) begin
                    tests++;
                    if (c - last_c !== 7) begin
                        fails++; $display("FAIL rr_spacing%0d: got %0d want 7", res_n, c - last_c);
                    end
                end
                last_c = c;
                res_n++;
            end
        end
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.req_valid = '0;
        tests++;
        if (res_n !== 4) begin
            fails++; $display("FAIL rr_count: got %0d want 4", res_n);
        end
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (pulses[i] !== 1) begin
                fails++; $display("FAIL rr_pulses%0d: got %0d want 1", i, pulses[i]);
            end
        end
    endtask

    task automatic test_backpressure;
        int n;
        @(negedge clk);
        bus.req_data[10 +: 5] = 5'd25;
        bus.req_valid         = 4'b0100;
        #1;
        tests++;
        if (bus.req_ready !== 4'b0100) begin
            fails++; $display("FAIL bp_grant: got %b want 0100", bus.req_ready);
        end
        @(negedge clk);
        bus.req_data[0 +: 5] = 5'd9;
        bus.req_valid        = 4'b0001;
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            #1;
            tests++;
            if ({bus.out_valid, bus.out_bcd, bus.out_id, bus.req_ready} !== {1'b1, 8'h25, 2'd2, 4'b0000}) begin
                fails++;
                $display("FAIL bp_hold%0d: got v=%b bcd=%h id=%0d rdy=%b want 1 25 2 0000",
                         i, bus.out_valid, bus.out_bcd, bus.out_id, bus.req_ready);
            end
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        #1;
        tests++;
        if ({bus.out_valid, bus.req_ready} !== {1'b0, 4'b0001}) begin
            fails++;
            $display("FAIL bp_resume: got v=%b rdy=%b want 0 0001", bus.out_valid, bus.req_ready);
        end
        @(negedge clk);
        bus.req_valid = '0;
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if ({bus.out_valid, bus.out_bcd, bus.out_id} !== {1'b1, 8'h09, 2'd0}) begin
            fails++;
            $display("FAIL bp_next: got v=%b bcd=%h id=%0d want 1 09 0", bus.out_valid, bus.out_bcd, bus.out_id);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_fairness;
        int   grants[$];
        int   ids[$];
        int   exp_g[6];
        bit   withdrawn;
        int   n;
        exp_g     = '{1, 3, 1, 3, 1, 1};
        withdrawn = 1'b0;
        do_reset;
        bus.req_data[5 +: 5]  = 5'd12;
        bus.req_data[15 +: 5] = 5'd30;
        bus.req_valid = 4'b1010;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 120 && grants.size() < 6; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            for (int i = 0; i < 4; i++) if (bus.req_ready[i]) grants.push_back(i);
            if (grants.size() == 5 && !withdrawn) begin
                bus.req_valid[3] = 1'b0;
                withdrawn = 1'b1;
            end
            if (bus.out_valid) begin
                ids.push_back(int'(bus.out_id));
                tests++;
                if (bus.out_bcd !== ((bus.out_id == 2'd1) ? 8'h12 : 8'h30)) begin
                    fails++; $display("FAIL fair_bcd: got %h for id %0d", bus.out_bcd, bus.out_id);
                end
            end
        end
        @(negedge clk);
        bus.req_valid = '0;
        n = 0;
        while (busy0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        bus.out_ready = 1'b0;
        tests++;
        if (grants.size() !== 6) begin
            fails++; $display("FAIL fair_grant_count: got %0d want 6", grants.size());
        end
        for (int i = 0; i < 6 && i < grants.size(); i++) begin
            tests++;
            if (grants[i] !== exp_g[i]) begin
                fails++; $display("FAIL fair_grant%0d: got %0d want %0d", i, grants[i], exp_g[i]);
            end
        end
        for (int i = 0; i < 5 && i < ids.size(); i++) begin
            tests++;
            if (ids[i] !== exp_g[i]) begin
                fails++; $display("FAIL fair_id%0d: got %0d want %0d", i, ids[i], exp_g[i]);
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [3:0] rdy;
        logic [7:0] bcd;
        logic [1:0] id;
        logic       ovf;
        int         lat;
        bit         seen;
        @(negedge clk);
        bus.req_data[15 +: 5] = 5'd20;
        bus.req_valid         = 4'b1000;
        @(negedge clk);
        bus.req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({bus.out_valid, bus.out_bcd, bus.out_id, bus.out_ovf, busy0, bus.req_ready} !== 17'h0) begin
            fails++;
            $display("FAIL midreset_clear: got v=%b bcd=%h id=%0d ovf=%b busy=%b rdy=%b want all zero",
                     bus.out_valid, bus.out_bcd, bus.out_id, bus.out_ovf, busy0, bus.req_ready);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        tests++;
        if (seen !== 1'b0) begin
            fails++; $display("FAIL midreset_no_valid: got out_valid seen=%b want 0", seen);
        end
        convert(0, 2, 5'd22, rdy, bcd, id, ovf, lat);
        tests++;
        if ({rdy, bcd, id, ovf} !== {4'b0100, 8'h22, 2'd2, 1'b0} || lat !== 6) begin
            fails++;
            $display("FAIL midreset_next: got rdy=%b bcd=%h id=%0d ovf=%b lat=%0d want 0100 22 2 0 6",
                     rdy, bcd, id, ovf, lat);
        end
    endtask

    task automatic test_overflow_sweep;
        logic [3:0] rdy;
        logic [7:0] bcd;
        logic [1:0] id;
        logic       ovf;
        int         lat;
        logic [7:0] e;
        convert(1, 0, 5'd17, rdy, bcd, id, ovf, lat);
        tests++;
        if ({bcd, ovf, id} !== {8'h07, 1'b1, 2'd0} || lat !== 6) begin
            fails++;
            $display("FAIL ovf_17: got bcd=%h ovf=%b id=%0d lat=%0d want 07 1 0 6", bcd, ovf, id, lat);
        end
        convert(1, 1, 5'd9, rdy, bcd, id, ovf, lat);
        tests++;
        if ({bcd, ovf, id} !== {8'h09, 1'b0, 2'd1}) begin
            fails++; $display("FAIL ovf_9: got bcd=%h ovf=%b id=%0d want 09 0 1", bcd, ovf, id);
        end
        for (int v = 0; v < 32; v++) begin
            e[7:4] = 4'(v / 10);
            e[3:0] = 4'(v % 10);
            convert(0, v % 4, 5'(v), rdy, bcd, id, ovf, lat);
            tests++;
            if ({bcd, id, ovf, lat == 6} !== {e, 2'(v % 4), 1'b0, 1'b1}) begin
                fails++;
                $display("FAIL sweep_%0d: got bcd=%h id=%0d ovf=%b lat=%0d want %h %0d 0 6",
                         v, bcd, id, ovf, lat, e, v % 4);
            end
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_round_robin;
        test_backpressure;
        test_fairness;
        test_reset_mid;
        test_overflow_sweep;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
